// File: rtl/ej32_pkg.sv
// Shared types for the eJ32 data-stack slice: stack op codes, error flags, default depth.
package ej32_pkg;

  localparam int SS_DEPTH_DEF = 64;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_REPL = 3'd3,
    OP_PICK = 3'd4,
    OP_CLR  = 3'd5
  } stack_op_t;

  typedef struct packed {
    logic ovf;
    logic unf;
  } ss_err_t;

endpackage

// File: rtl/ej32_spram.sv
// Stack storage: one synchronous write port, one asynchronous read port, contents never reset.
module ej32_spram #(
  parameter int DW    = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ej32_sstack.sv
// eJ32 data stack below TOS: supplies NOS on s, plus PICK/REPL/CLR and depth/status/error flags.
// Define EJ32_SS_GUARD_EN to block PUSH-while-full and POP-while-empty instead of wrapping.
module ej32_sstack
  import ej32_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = SS_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    op,
  input  logic [DW-1:0] vi,
  input  logic [AW-1:0] idx,
  output logic [DW-1:0] s,
  output logic [DW-1:0] pk,
  output logic          pk_v,
  output logic [AW:0]   depth,
  output logic          full,
  output logic          empty,
  output logic [1:0]    err
);

  localparam logic [AW:0] FULL_DEPTH = (AW+1)'(DEPTH);

  stack_op_t     opc;
  logic [AW-1:0] sp;
  logic [AW:0]   depth_q;
  ss_err_t       err_q;
  logic          is_full, is_empty;
  logic          push_ok, pop_ok;
  logic          we;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] rdata;

  assign opc      = (op > 3'd5) ? OP_NOP : stack_op_t'(op);
  assign is_full  = (depth_q == FULL_DEPTH);
  assign is_empty = (depth_q == '0);

`ifdef EJ32_SS_GUARD_EN
  assign push_ok = !is_full;
  assign pop_ok  = !is_empty;
`else
  assign push_ok = 1'b1;
  assign pop_ok  = 1'b1;
`endif

  // The single read port serves PICK and the NOS refill on POP; both use the pre-update sp.
  assign raddr = (opc == OP_PICK) ? (sp - AW'(1) - idx) : (sp - AW'(2));

  always_comb begin
    we    = 1'b0;
    waddr = sp;
    if (rst) begin
      case (opc)
        OP_PUSH: we = push_ok;
        OP_REPL: begin
          we    = !is_empty;
          waddr = sp - AW'(1);
        end
        default: ;
      endcase
    end
  end

  ej32_spram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (vi),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      sp      <= '0;
      depth_q <= '0;
      s       <= '0;
      pk      <= '0;
      pk_v    <= 1'b0;
      err_q   <= '0;
    end else begin
      pk_v <= (opc == OP_PICK);
      case (opc)
        OP_PUSH: begin
          if (push_ok) begin
            sp <= sp + AW'(1);
            s  <= vi;
            if (!is_full) depth_q <= depth_q + (AW+1)'(1);
          end else begin
            err_q.ovf <= 1'b1;
          end
        end
        OP_POP: begin
          if (pop_ok) begin
            sp <= sp - AW'(1);
            s  <= rdata;
            if (!is_empty) depth_q <= depth_q - (AW+1)'(1);
          end else begin
            err_q.unf <= 1'b1;
          end
        end
        OP_REPL: begin
          if (is_empty) err_q.unf <= 1'b1;
          else          s <= vi;
        end
        OP_PICK: begin
          if ({1'b0, idx} >= depth_q) begin
            pk        <= '0;
            err_q.unf <= 1'b1;
          end else begin
            pk <= rdata;
          end
        end
        OP_CLR: begin
          sp      <= '0;
          depth_q <= '0;
          err_q   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign depth = depth_q;
  assign full  = is_full;
  assign empty = is_empty;
  assign err   = err_q;

endmodule
